// File: rtl/linear_pkg.sv
// Shared types and default constants for the quantized linear-layer datapath.
// The saturation limit is the largest positive value of a signed accumulator.
package linear_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int DEF_PRECISION      = 8;
  localparam int DEF_BIAS_PRECISION = 32;
  localparam int DEF_N_INPUTS       = 784;
  localparam int DEF_N_OUTPUTS      = 10;

  // Largest positive value of a w-bit signed number (valid for 2 <= w <= 64).
  function automatic logic [63:0] sat_limit(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  localparam logic [63:0] DEF_SAT_LIMIT = sat_limit(DEF_BIAS_PRECISION);

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// W-bit unsigned adder; with MAC_ACCUMULATOR_SATURATE_EN the sum clamps at the
// signed positive maximum and sat flags the clamp, otherwise it wraps.
module mac_sat_add
  import linear_pkg::*;
#(
  parameter int W = DEF_BIAS_PRECISION
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
`ifdef MAC_ACCUMULATOR_SATURATE_EN
  ,
  output logic         sat
`endif
);

`ifdef MAC_ACCUMULATOR_SATURATE_EN
  localparam int WP1 = W + 1;
  localparam logic [W:0] LIMIT = WP1'(sat_limit(W));

  logic [W:0] full;

  // a never exceeds LIMIT, so a clamped operand stays clamped on further adds.
  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    if (full > LIMIT) begin
      sum = LIMIT[W-1:0];
      sat = 1'b1;
    end else begin
      sum = full[W-1:0];
      sat = 1'b0;
    end
  end
`else
  always_comb begin
    sum = a + b;
  end
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Per-neuron multiply-accumulate: sums x*w and x over N_INPUTS pairs, then holds
// the result for a valid/ready handshake. Optional: MAC_ACCUMULATOR_SATURATE_EN.
module mac_accumulator
  import linear_pkg::*;
#(
  parameter int PRECISION      = DEF_PRECISION,
  parameter int BIAS_PRECISION = DEF_BIAS_PRECISION,
  parameter int N_INPUTS       = DEF_N_INPUTS,
  parameter int N_OUTPUTS      = DEF_N_OUTPUTS,
  parameter int IDX_W          = (N_OUTPUTS > 1) ? $clog2(N_OUTPUTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PRECISION-1:0]      x,
  input  logic [PRECISION-1:0]      w,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BIAS_PRECISION-1:0] acc,
  output logic [BIAS_PRECISION-1:0] ai,
  output logic [IDX_W-1:0]          neuron_idx,
  output logic                      out_last
`ifdef MAC_ACCUMULATOR_SATURATE_EN
  ,
  output logic                      ovf
`endif
);

  localparam int PW    = 2 * PRECISION;
  localparam int CNT_W = clog2_min1(N_INPUTS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OUTPUTS - 1);

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BIAS_PRECISION-1:0] acc_q, acc_d, ai_q, ai_d;
  logic [BIAS_PRECISION-1:0] acc_sum, ai_sum;
  logic [BIAS_PRECISION-1:0] acc_add, ai_add;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [PW-1:0]             prod;
  logic                      in_fire, out_fire;

  assign prod    = PW'(x) * PW'(w);
  assign acc_add = BIAS_PRECISION'(prod);
  assign ai_add  = BIAS_PRECISION'(x);

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

`ifdef MAC_ACCUMULATOR_SATURATE_EN
  logic acc_sat, ai_sat;
  logic ovf_q, ovf_d;

  mac_sat_add #(.W(BIAS_PRECISION)) u_acc_add (
    .a   (acc_q),
    .b   (acc_add),
    .sum (acc_sum),
    .sat (acc_sat)
  );

  mac_sat_add #(.W(BIAS_PRECISION)) u_ai_add (
    .a   (ai_q),
    .b   (ai_add),
    .sum (ai_sum),
    .sat (ai_sat)
  );
`else
  mac_sat_add #(.W(BIAS_PRECISION)) u_acc_add (
    .a   (acc_q),
    .b   (acc_add),
    .sum (acc_sum)
  );

  mac_sat_add #(.W(BIAS_PRECISION)) u_ai_add (
    .a   (ai_q),
    .b   (ai_add),
    .sum (ai_sum)
  );
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ai_d    = ai_q;
    idx_d   = idx_q;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      ACCUM: begin
        if (in_fire) begin
          acc_d = acc_sum;
          ai_d  = ai_sum;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
          ovf_d = ovf_q | acc_sat | ai_sat;
`endif
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_fire) begin
          acc_d   = '0;
          ai_d    = '0;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
          ovf_d   = 1'b0;
`endif
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
      ai_q    <= '0;
      idx_q   <= '0;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ai_q    <= ai_d;
      idx_q   <= idx_d;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign acc        = acc_q;
  assign ai         = ai_q;
  assign neuron_idx = idx_q;
  assign out_last   = out_valid & (idx_q == IDX_LAST);
`ifdef MAC_ACCUMULATOR_SATURATE_EN
  assign ovf        = ovf_q;
`endif

endmodule
